// File: rtl/otter_mem_arbiter_if.sv
// Burst bus between the OTTER I/D cache engines, the memory arbiter and main memory.
// slave = the arbiter's view; master = the caches and memory that surround it.
interface otter_mem_arbiter_if #(
   parameter int WORDS_PER_LINE = 8
);
   localparam int BEAT_W = $clog2(WORDS_PER_LINE);

   logic              ic_req;
   logic [31:0]       ic_addr;
   logic              ic_rvalid;
   logic              ic_done;
   logic              dc_req;
   logic              dc_we;
   logic [31:0]       dc_addr;
   logic [31:0]       dc_wdata;
   logic              dc_rvalid;
   logic              dc_wready;
   logic              dc_done;
   logic [BEAT_W-1:0] beat_idx;
   logic [31:0]       rdata;
   logic              mem_req;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   // Handshake: a cache holds req until its done pulse; a memory beat completes in
   // the cycle mem_req & mem_ack, and mem_req/mem_we/mem_addr are stable until then.
   modport slave (
      input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
      output ic_rvalid, ic_done, dc_rvalid, dc_wready, dc_done, beat_idx, rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
      input  ic_rvalid, ic_done, dc_rvalid, dc_wready, dc_done, beat_idx, rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache line bursts.
// Sequences the beats of a granted burst and steers the memory strobes to its owner.
module otter_mem_arbiter #(
   parameter int WORDS_PER_LINE = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   otter_mem_arbiter_if.slave    bus,
   output logic [1:0]            dbg_state
);
   localparam int BEAT_W = $clog2(WORDS_PER_LINE);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BURST_I = 2'd1,
      BURST_D = 2'd2
   } state_t;

   state_t               state;
   logic [BEAT_W-1:0]    cnt;
   logic [31-BEAT_W-2:0] base;
   logic                 we_q;
   logic                 lg;
   logic                 req_q;

   logic grant_i, grant_d, last, on, ack, in_i, in_d;
   logic unused_addr_bits;

   // lg remembers the last winner (1 = D), so a tie goes to the other requester.
   assign grant_d = bus.dc_req & (~bus.ic_req | ~lg);
   assign grant_i = bus.ic_req & (~bus.dc_req | lg);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         base  <= '0;
         we_q  <= 1'b0;
         lg    <= 1'b0;
         req_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (grant_d) begin
                  base  <= bus.dc_addr[31:BEAT_W+2];
                  we_q  <= bus.dc_we;
                  lg    <= 1'b1;
                  req_q <= 1'b1;
                  state <= BURST_D;
               end else if (grant_i) begin
                  base  <= bus.ic_addr[31:BEAT_W+2];
                  we_q  <= 1'b0;
                  lg    <= 1'b0;
                  req_q <= 1'b1;
                  state <= BURST_I;
               end
            end
            BURST_I, BURST_D: begin
               if (bus.mem_ack) begin
                  if (cnt == LAST_BEAT) begin
                     cnt   <= '0;
                     req_q <= 1'b0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               cnt   <= '0;
               req_q <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Every output is forced low while RST is high, so an aborted burst never strobes.
   assign on   = ~RST;
   assign in_i = (state == BURST_I);
   assign in_d = (state == BURST_D);
   assign last = (cnt == LAST_BEAT);
   assign ack  = bus.mem_ack & on;

   assign bus.mem_req   = req_q & on;
   assign bus.mem_we    = req_q & we_q & on;
   assign bus.mem_addr  = on ? {base, cnt, 2'b00} : 32'd0;
   assign bus.beat_idx  = on ? cnt : '0;
   assign bus.mem_wdata = on ? bus.dc_wdata : 32'd0;
   assign bus.rdata     = on ? bus.mem_rdata : 32'd0;

   assign bus.ic_rvalid = ack & in_i;
   assign bus.ic_done   = ack & in_i & last;
   assign bus.dc_rvalid = ack & in_d & ~we_q;
   assign bus.dc_wready = ack & in_d & we_q;
   assign bus.dc_done   = ack & in_d & last;

   assign dbg_state = on ? state : IDLE;

   assign unused_addr_bits = ^{bus.ic_addr[BEAT_W+1:0], bus.dc_addr[BEAT_W+1:0]};
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: cache agents push expected beats into per-cache queues,
// a round-robin ownership model plus a monitor pops and compares every memory cycle.
module tb_otter_mem_arbiter;
   localparam int WPL = 8;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] dbg_state;

   otter_mem_arbiter_if #(.WORDS_PER_LINE(WPL)) bus();
   otter_mem_arbiter #(.WORDS_PER_LINE(WPL)) dut (
      .CLK(CLK), .RST(RST), .bus(bus), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   beat_t       exp_i_q[$];
   beat_t       exp_d_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] d_wbase  = 32'd0;
   int          ack_mode = 0;
   int          cyc      = 0;

   function automatic logic [31:0] rd_hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Memory model and D-cache write data source.
   always_comb bus.mem_rdata = rd_hash(bus.mem_addr);
   always_comb bus.dc_wdata  = d_wbase + 32'(bus.beat_idx);

   always @(posedge CLK) begin
      #1;
      cyc++;
      case (ack_mode)
         0:       bus.mem_ack = 1'b1;
         1:       bus.mem_ack = (cyc % 3 == 0);
         default: bus.mem_ack = ($urandom_range(0, 2) != 0);
      endcase
   end

   // ---------------- driver tasks ----------------
   task automatic push_line(input bit is_d, input logic [31:0] addr, input logic we,
                            input logic [31:0] wb);
      beat_t b;
      for (int k = 0; k < WPL; k++) begin
         b.addr  = (addr & ~32'(4 * WPL - 1)) + 32'(4 * k);
         b.we    = we;
         b.wdata = wb + 32'(k);
         if (is_d) exp_d_q.push_back(b);
         else      exp_i_q.push_back(b);
      end
   endtask

   task automatic wait_done(input bit is_d, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         if (is_d ? bus.dc_done : bus.ic_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic ic_burst(input logic [31:0] addr, input int n);
      bit ok;
      for (int i = 0; i < n; i++) push_line(1'b0, addr, 1'b0, 32'd0);
      bus.ic_addr = addr;
      bus.ic_req  = 1'b1;
      for (int i = 0; i < n; i++) begin
         wait_done(1'b0, ok);
         chk("ic_done_seen", ok, 1);
         if (!ok) break;
      end
      @(posedge CLK); #1;
      bus.ic_req = 1'b0;
   endtask

   task automatic dc_burst(input logic [31:0] addr, input logic we, input logic [31:0] wb,
                           input int n, input bit mutate);
      bit ok;
      bit seen;
      for (int i = 0; i < n; i++) push_line(1'b1, addr, we, wb);
      d_wbase     = wb;
      bus.dc_addr = addr;
      bus.dc_we   = we;
      bus.dc_req  = 1'b1;
      if (mutate) begin
         seen = 1'b0;
         for (int c = 0; c < 500; c++) begin
            @(negedge CLK);
            if (bus.mem_req && bus.beat_idx == 3'd3) begin
               seen = 1'b1;
               break;
            end
         end
         chk("dc_reached_beat3", seen, 1);
         @(posedge CLK); #1;
         bus.dc_addr = ~addr;
         bus.dc_we   = ~we;
         bus.dc_req  = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         wait_done(1'b1, ok);
         chk("dc_done_seen", ok, 1);
         if (!ok) break;
      end
      @(posedge CLK); #1;
      bus.dc_req = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   // Ownership model: an idle arbiter grants a lone requester, or on a tie the one
   // that did not win last; the owner then gets exactly WPL acknowledged beats.
   bit    m_busy  = 1'b0;
   bit    m_own_d = 1'b0;
   bit    m_lg    = 1'b0;
   int    m_left  = 0;
   beat_t h;

   always @(negedge CLK) begin
      if (RST) begin
         chk("reset_ctrl", {bus.mem_req, bus.mem_we, bus.ic_rvalid, bus.ic_done,
                            bus.dc_rvalid, bus.dc_wready, bus.dc_done, dbg_state}, 0);
         chk("reset_addr", bus.mem_addr, 0);
         chk("reset_beat", bus.beat_idx, 0);
         chk("reset_rdata", bus.rdata, 0);
         m_busy = 1'b0;
         m_lg   = 1'b0;
         exp_i_q.delete();
         exp_d_q.delete();
      end else if (m_busy) begin
         if (m_own_d) h = (exp_d_q.size() > 0) ? exp_d_q[0] : '0;
         else         h = (exp_i_q.size() > 0) ? exp_i_q[0] : '0;
         chk("mem_req", bus.mem_req, 1);
         chk("mem_addr", bus.mem_addr, h.addr);
         chk("mem_we", bus.mem_we, h.we);
         chk("beat_idx", bus.beat_idx, WPL - m_left);
         if (h.we) chk("mem_wdata", bus.mem_wdata, h.wdata);
         if (bus.mem_ack) begin
            chk("strobes", {bus.ic_rvalid, bus.dc_rvalid, bus.dc_wready},
                m_own_d ? {1'b0, ~h.we, h.we} : 3'b100);
            chk("done", {bus.ic_done, bus.dc_done},
                (m_left == 1) ? (m_own_d ? 2'b01 : 2'b10) : 2'b00);
            if (!h.we) chk("rdata", bus.rdata, rd_hash(h.addr));
            if (m_own_d && exp_d_q.size() > 0) void'(exp_d_q.pop_front());
            if (!m_own_d && exp_i_q.size() > 0) void'(exp_i_q.pop_front());
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
         end else begin
            chk("wait_strobes", {bus.ic_rvalid, bus.ic_done, bus.dc_rvalid,
                                 bus.dc_wready, bus.dc_done}, 0);
         end
      end else begin
         chk("idle_req", bus.mem_req, 0);
         chk("idle_strobes", {bus.ic_rvalid, bus.ic_done, bus.dc_rvalid,
                              bus.dc_wready, bus.dc_done}, 0);
         if (bus.ic_req || bus.dc_req) begin
            m_own_d = (bus.ic_req && bus.dc_req) ? ~m_lg : bus.dc_req;
            m_lg    = m_own_d;
            m_busy  = 1'b1;
            m_left  = WPL;
            chk("q_depth_at_grant",
                (m_own_d ? exp_d_q.size() : exp_i_q.size()) >= WPL, 1);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit found;
      RST         = 1'b1;
      bus.ic_req  = 1'b0;
      bus.ic_addr = 32'd0;
      bus.dc_req  = 1'b0;
      bus.dc_we   = 1'b0;
      bus.dc_addr = 32'd0;
      bus.mem_ack = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      // Single I-cache line, memory always ready: beats 0x1220..0x123C.
      ic_burst(32'h0000_1234, 1);
      idle_cycles(2);

      // Simultaneous requests held for two lines each: D, I, D, I.
      fork
         ic_burst(32'h0000_2000, 2);
         dc_burst(32'h0000_3000, 1'b0, 32'd0, 2, 1'b0);
      join
      idle_cycles(2);

      // Writeback with an ack every third cycle.
      ack_mode = 1;
      dc_burst(32'h8000_0040, 1'b1, 32'h0000_00A0, 1, 1'b0);
      idle_cycles(2);

      // Address/direction change and request drop mid-burst.
      ack_mode = 2;
      dc_burst(32'h0000_5A60, 1'b0, 32'd0, 1, 1'b1);
      idle_cycles(4);

      // Reset in the middle of an I burst, then a tie that D must win.
      ack_mode = 0;
      push_line(1'b0, 32'h0000_4400, 1'b0, 32'd0);
      bus.ic_addr = 32'h0000_4400;
      bus.ic_req  = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge CLK);
         if (bus.mem_req && bus.beat_idx == 3'd4) begin
            found = 1'b1;
            break;
         end
      end
      chk("reached_beat4", found, 1);
      @(posedge CLK); #1;
      RST        = 1'b1;
      bus.ic_req = 1'b0;
      @(negedge CLK);
      chk("rst_mid_req", bus.mem_req, 0);
      chk("rst_mid_done", bus.ic_done, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      fork
         begin
            @(negedge CLK);
            chk("post_rst_req", bus.mem_req, 0);
            chk("post_rst_done", bus.ic_done, 0);
            chk("post_rst_beat", bus.beat_idx, 0);
         end
         ic_burst(32'h0000_6000, 1);
         dc_burst(32'h0000_7000, 1'b1, 32'h0000_0100, 1, 1'b0);
      join
      idle_cycles(2);

      // I request left high one cycle past done starts a second burst.
      ic_burst(32'h0000_9000, 2);
      idle_cycles(2);

      // Random traffic from both caches with random wait states.
      ack_mode = 2;
      fork
         for (int i = 0; i < 8; i++) begin
            idle_cycles($urandom_range(0, 6));
            ic_burst($urandom(), $urandom_range(1, 2));
         end
         for (int i = 0; i < 8; i++) begin
            idle_cycles($urandom_range(0, 6));
            dc_burst($urandom(), 1'($urandom_range(0, 1)), $urandom(),
                     $urandom_range(1, 2), 1'b0);
         end
      join
      idle_cycles(5);

      chk("i_queue_drained", exp_i_q.size(), 0);
      chk("d_queue_drained", exp_d_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares the single main-memory port between the OTTER I-cache and D-cache refill/writeback engines.
- Each cache issues whole-line bursts: I-cache reads only; D-cache reads, or writes back dirty lines.
- The block arbitrates between them round-robin, sequences the beats and generates per-beat addresses.
- It steers memory strobes to the granted cache and holds the pipeline-facing caches off until their grant.

Parameters:
WORDS_PER_LINE, 8, 32-bit beats per burst; power of two, minimum 2
BEAT_W, $clog2(WORDS_PER_LINE), beat counter width (derived; not overridden)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
ic_req  in  1  I-cache burst request; held until ic_done
ic_addr  in  32  I-cache line base address; low log2(4*WORDS_PER_LINE) bits ignored
ic_rvalid  out  1  mem_rdata holds an I-cache beat this cycle
ic_done  out  1  one-cycle pulse on final I-cache beat
dc_req  in  1  D-cache burst request; held until dc_done
dc_we  in  1  1 = writeback burst, 0 = refill; sampled at grant
dc_addr  in  32  D-cache line base address
dc_wdata  in  32  writeback word for beat index beat_idx
dc_rvalid  out  1  mem_rdata holds a D-cache beat this cycle
dc_wready  out  1  dc_wdata accepted this cycle
dc_done  out  1  one-cycle pulse on final D-cache beat
beat_idx  out  BEAT_W  current beat number within the burst
rdata  out  32  mem_rdata passed through to both caches
mem_req  out  1  beat request to memory
mem_we  out  1  beat is a write
mem_addr  out  32  word address of the current beat
mem_wdata  out  32  equals dc_wdata
mem_rdata  in  32  read data; valid when mem_ack=1 and mem_we=0
mem_ack  in  1  memory completes the current beat this cycle

Behaviour:
- FSM states: IDLE, BURST_I, BURST_D. Registers:
  - state
  - beat counter cnt
  - latched base address
  - latched we
  - last-grant flag lg (0 = I, 1 = D)
- Reset (RST high at a CLK edge):
  - state=IDLE, cnt=0, lg=0, so the first tie goes to D.
  - All outputs are 0 during reset, including mem_req.
  - A reset mid-burst aborts the burst. No done pulse is issued, and mem_req is 0 in the following cycle.
- Arbitration (IDLE only):
  - Only ic_req → grant I.
  - Only dc_req → grant D.
  - Both → grant the one not equal to lg.
  - On grant: latch the base address, latch the write flag (dc_we for D, 0 for I), set cnt=0, update lg.
  - The state moves to BURST_x at the next edge.
  - Request-to-first-mem_req latency is 1 cycle.
  - No request → stay in IDLE.
- BURST_x:
  - mem_req=1.
  - mem_we = latched we.
  - mem_addr = {base[31:BEAT_W+2], cnt, 2'b00}.
  - beat_idx = cnt.
  - mem_req, mem_we and mem_addr are stable until mem_ack.
  - mem_ack=0 → hold everything; wait states are unbounded.
  - mem_ack=1 and cnt<WORDS_PER_LINE-1 → cnt+1 at the edge.
  - mem_ack=1 and cnt==WORDS_PER_LINE-1:
    - x_done=1 combinationally in that cycle.
    - Next state IDLE, cnt=0.
- Strobes:
  - ic_rvalid = mem_ack & BURST_I.
  - dc_rvalid = mem_ack & BURST_D & !we.
  - dc_wready = mem_ack & BURST_D & we.
  - All are 0 in IDLE.
- Data paths: rdata = mem_rdata and mem_wdata = dc_wdata, both combinational and unregistered.
- Turnaround:
  - At least one IDLE cycle separates bursts.
  - The minimum burst occupancy is WORDS_PER_LINE cycles plus 1 IDLE cycle.
- Request rules:
  - A requester deasserts req no later than the edge that ends its done cycle.
  - A req still high in the following IDLE cycle is treated as a new request.
  - Dropping req mid-burst is ignored; the burst runs to completion.
- The latched address and we are immune to input changes during a burst.
- mem_ack in IDLE is ignored.
- Counter wrap:
  - cnt never exceeds WORDS_PER_LINE-1.
  - The address beat field wraps within the line, never carrying into the tag bits.

Test Plan:
- Reset then ic_req=1, ic_addr=0x0000_1234, mem_ack=1 always:
  - mem_req rises 1 cycle later.
  - mem_addr = 0x1220, 0x1224, …, 0x123C.
  - ic_rvalid high 8 cycles; ic_done on the 8th beat.
  - IDLE next cycle.
- ic_req and dc_req asserted in the same cycle after reset:
  - D granted first and I second.
  - With both held continuously, grants alternate D,I,D,I.
- dc_req=1, dc_we=1, dc_addr=0x8000_0040, dc_wdata=0xA0+beat_idx, mem_ack only every 3rd cycle:
  - mem_we=1 and mem_wdata=0xA0..0xA7 in order, each held until its ack.
  - dc_wready pulses 8 times; dc_done on the last; dc_rvalid never high.
- During a D burst, change dc_addr and dc_we and drop dc_req at beat 3:
  - The burst completes with the original address and direction.
  - No new grant follows.
- Assert RST at beat 5 of an I burst:
  - The next cycle has mem_req=0, ic_done=0, cnt=0.
  - After RST falls, with ic_req=1 and dc_req=1, D wins the tie.
- Leave ic_req high for 1 cycle after ic_done:
  - A second I burst starts, confirming the request rule.
  - Memory sees one IDLE cycle of mem_req=0 between the bursts.
